// File: rtl/route_sequencer_if.sv
// Handshake bundle between a route sequencer and its host / maneuver detectors.
// The slave modport is the sequencer side; master is the host and detector side.
interface route_sequencer_if #(
    parameter int NSTEPS = 8
);
    localparam int AW = $clog2(NSTEPS);

    logic          prog_we;
    logic [AW-1:0] prog_addr;
    logic [3:0]    prog_data;
    logic          start;
    logic          abort;
    logic          doneS;
    logic          doneL;
    logic          doneR;
    logic          errL;
    logic          errR;
    logic          enS;
    logic          enL;
    logic          enR;
    logic [1:0]    count;
    logic [AW-1:0] step_idx;
    logic          busy;
    logic          route_done;
    logic [1:0]    fault_code;

    modport master (
        output prog_we, prog_addr, prog_data, start, abort,
        output doneS, doneL, doneR, errL, errR,
        input  enS, enL, enR, count, step_idx, busy, route_done, fault_code
    );

    modport slave (
        input  prog_we, prog_addr, prog_data, start, abort,
        input  doneS, doneL, doneR, errL, errR,
        output enS, enL, enR, count, step_idx, busy, route_done, fault_code
    );
endinterface

// File: rtl/route_sequencer.sv
// Steps through a programmable table of maneuvers, enabling one detector at a
// time, with a per-step watchdog and a quiet settle gap between steps.
module route_sequencer #(
    parameter int          NSTEPS  = 8,
    parameter logic [23:0] TIMEOUT = 24'd10_000_000,
    parameter int          SETTLE  = 4
) (
    input logic             clk,
    input logic             rst_n,
    route_sequencer_if.slave bus
);
    localparam int AW = $clog2(NSTEPS);
    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    localparam logic [AW-1:0] LAST_STEP   = AW'(NSTEPS - 1);
    localparam logic [AW-1:0] STEP_ONE    = AW'(1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);
    localparam logic [SW-1:0] SETTLE_ONE  = SW'(1);
    localparam logic [23:0]   TIMER_LAST  = TIMEOUT - 24'd1;

    localparam logic [1:0] ACT_STRAIGHT = 2'b00;
    localparam logic [1:0] ACT_LEFT     = 2'b01;
    localparam logic [1:0] ACT_RIGHT    = 2'b10;
    localparam logic [1:0] ACT_STOP     = 2'b11;

    localparam logic [1:0] FC_NONE    = 2'b00;
    localparam logic [1:0] FC_TIMEOUT = 2'b01;
    localparam logic [1:0] FC_DETERR  = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_SETTLE,
        S_DONE,
        S_FAULT
    } state_t;

    state_t        state_reg,    state_next;
    logic [AW-1:0] step_idx_reg, step_idx_next;
    logic [1:0]    count_reg,    count_next;
    logic [2:0]    en_reg,       en_next;      // {R, L, S}
    logic [1:0]    fault_reg,    fault_next;
    logic [23:0]   timer_reg,    timer_next;
    logic [SW-1:0] settle_reg,   settle_next;

    logic       busy;
    logic       table_we;
    logic [3:0] cur_entry;
    logic [1:0] cur_action;
    logic [1:0] cur_count;
    logic       active_done;
    logic       active_err;

    assign busy     = (state_reg == S_ISSUE) || (state_reg == S_WAIT) || (state_reg == S_SETTLE);
    assign table_we = bus.prog_we && !busy;

    // Route table: kept in flops so that reset can restore every entry to STOP.
    logic [3:0] entry_arr [NSTEPS];
    generate
        for (genvar gi = 0; gi < NSTEPS; gi++) begin : g_table
            logic [3:0] entry_reg;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    entry_reg <= {ACT_STOP, 2'b00};
                end else if (table_we && (bus.prog_addr == AW'(gi))) begin
                    entry_reg <= bus.prog_data;
                end
            end
            assign entry_arr[gi] = entry_reg;
        end
    endgenerate

    assign cur_entry  = entry_arr[step_idx_reg];
    assign cur_action = cur_entry[3:2];
    assign cur_count  = cur_entry[1:0];

    // Only the detector whose enable is currently driven may end or fail a step.
    assign active_done = |(en_reg & {bus.doneR, bus.doneL, bus.doneS});
    assign active_err  = (en_reg[1] & bus.errL) | (en_reg[2] & bus.errR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= S_IDLE;
            step_idx_reg <= '0;
            count_reg    <= '0;
            en_reg       <= '0;
            fault_reg    <= FC_NONE;
            timer_reg    <= '0;
            settle_reg   <= '0;
        end else begin
            state_reg    <= state_next;
            step_idx_reg <= step_idx_next;
            count_reg    <= count_next;
            en_reg       <= en_next;
            fault_reg    <= fault_next;
            timer_reg    <= timer_next;
            settle_reg   <= settle_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        step_idx_next = step_idx_reg;
        count_next    = count_reg;
        en_next       = en_reg;
        fault_next    = fault_reg;
        timer_next    = timer_reg;
        settle_next   = settle_reg;

        if (bus.abort) begin
            state_next    = S_IDLE;
            en_next       = '0;
            step_idx_next = '0;
            timer_next    = '0;
            settle_next   = '0;
        end else begin
            case (state_reg)
                S_IDLE, S_DONE, S_FAULT: begin
                    en_next = '0;
                    if (bus.start) begin
                        state_next    = S_ISSUE;
                        step_idx_next = '0;
                        fault_next    = FC_NONE;
                        timer_next    = '0;
                    end
                end
                S_ISSUE: begin
                    timer_next = '0;
                    if (cur_action == ACT_STOP) begin
                        state_next = S_DONE;
                    end else begin
                        state_next = S_WAIT;
                        count_next = cur_count;
                        case (cur_action)
                            ACT_STRAIGHT: en_next = 3'b001;
                            ACT_LEFT:     en_next = 3'b010;
                            ACT_RIGHT:    en_next = 3'b100;
                            default:      en_next = 3'b000;
                        endcase
                    end
                end
                S_WAIT: begin
                    // Priority: detector error, then completion, then watchdog.
                    if (active_err) begin
                        state_next = S_FAULT;
                        fault_next = FC_DETERR;
                        en_next    = '0;
                    end else if (active_done) begin
                        state_next  = S_SETTLE;
                        settle_next = '0;
                        en_next     = '0;
                    end else if (timer_reg == TIMER_LAST) begin
                        state_next = S_FAULT;
                        fault_next = FC_TIMEOUT;
                        en_next    = '0;
                    end else begin
                        timer_next = timer_reg + 24'd1;
                    end
                end
                S_SETTLE: begin
                    en_next = '0;
                    if (settle_reg == SETTLE_LAST) begin
                        if (step_idx_reg == LAST_STEP) begin
                            state_next = S_DONE;
                        end else begin
                            state_next    = S_ISSUE;
                            step_idx_next = step_idx_reg + STEP_ONE;
                        end
                    end else begin
                        settle_next = settle_reg + SETTLE_ONE;
                    end
                end
                default: begin
                    state_next = S_IDLE;
                    en_next    = '0;
                end
            endcase
        end
    end

    assign bus.enS        = en_reg[0];
    assign bus.enL        = en_reg[1];
    assign bus.enR        = en_reg[2];
    assign bus.count      = count_reg;
    assign bus.step_idx   = step_idx_reg;
    assign bus.busy       = busy;
    assign bus.route_done = (state_reg == S_DONE);
    assign bus.fault_code = fault_reg;
endmodule

// File: tb/tb_route_sequencer.sv
// Directed bench for route_sequencer: LEFT/RIGHT route, timeout, detector
// error, full-table run, abort during WAIT and asynchronous reset mid-route.
module tb_route_sequencer;
    localparam int NSTEPS = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks_total  = 0;
    int   checks_passed = 0;

    route_sequencer_if #(.NSTEPS(NSTEPS)) bus ();

    route_sequencer #(
        .NSTEPS (NSTEPS),
        .TIMEOUT(24'd20),
        .SETTLE (4)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        checks_total++;
        if (got == exp) checks_passed++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic int en_vec();
        return int'({bus.enR, bus.enL, bus.enS});
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic prog(input logic [2:0] addr, input logic [3:0] data);
        bus.prog_we   = 1'b1;
        bus.prog_addr = addr;
        bus.prog_data = data;
        tick();
        bus.prog_we   = 1'b0;
        $display("prog entry %0d = %b", addr, data);
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wait_en(input string tag, input int mask, input int max_cycles);
        int n = 0;
        while (en_vec() != mask && n < max_cycles) begin
            tick();
            n++;
        end
        check_eq(tag, en_vec(), mask);
    endtask

    task automatic wait_done(input string tag, input int max_cycles);
        int n = 0;
        while (!bus.route_done && n < max_cycles) begin
            tick();
            n++;
        end
        check_eq(tag, int'(bus.route_done), 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bus.prog_we = 1'b0; bus.prog_addr = '0; bus.prog_data = '0;
        bus.start = 1'b0; bus.abort = 1'b0;
        bus.doneS = 1'b0; bus.doneL = 1'b0; bus.doneR = 1'b0;
        bus.errL = 1'b0; bus.errR = 1'b0;

        // Reset state
        repeat (2) tick();
        check_eq("rst_en",         en_vec(), 0);
        check_eq("rst_count",      int'(bus.count), 0);
        check_eq("rst_step",       int'(bus.step_idx), 0);
        check_eq("rst_busy",       int'(bus.busy), 0);
        check_eq("rst_route_done", int'(bus.route_done), 0);
        check_eq("rst_fault",      int'(bus.fault_code), 0);
        rst_n = 1'b1;
        tick();

        // LEFT c2, RIGHT c1, STOP
        prog(3'd0, 4'b0110);
        prog(3'd1, 4'b1001);
        prog(3'd2, 4'b1100);
        pulse_start();
        wait_en("t1_enL", 3'b010, 10);
        check_eq("t1_countL", int'(bus.count), 2);
        check_eq("t1_step0",  int'(bus.step_idx), 0);
        check_eq("t1_busy",   int'(bus.busy), 1);
        bus.doneL = 1'b1; tick(); bus.doneL = 1'b0;
        // four SETTLE cycles plus the ISSUE fetch cycle
        n = 0;
        while (en_vec() == 0 && n < 20) begin
            n++;
            tick();
        end
        check_eq("t1_low_cycles", n, 5);
        check_eq("t1_enR",        en_vec(), 3'b100);
        check_eq("t1_countR",     int'(bus.count), 1);
        check_eq("t1_step1",      int'(bus.step_idx), 1);
        bus.doneR = 1'b1; tick(); bus.doneR = 1'b0;
        wait_done("t1_done", 20);
        check_eq("t1_step2",     int'(bus.step_idx), 2);
        check_eq("t1_done_en",   en_vec(), 0);
        check_eq("t1_done_busy", int'(bus.busy), 0);
        $display("route t1 complete");

        // RIGHT step: inactive done/err ignored; simultaneous errR+doneR faults
        prog(3'd0, 4'b1011);
        prog(3'd1, 4'b1100);
        pulse_start();
        wait_en("t2_enR", 3'b100, 10);
        bus.doneL = 1'b1; bus.errL = 1'b1;
        repeat (3) tick();
        bus.doneL = 1'b0; bus.errL = 1'b0;
        check_eq("t2_inactive_en",    en_vec(), 3'b100);
        check_eq("t2_inactive_busy",  int'(bus.busy), 1);
        check_eq("t2_inactive_fault", int'(bus.fault_code), 0);
        bus.errR = 1'b1; bus.doneR = 1'b1; tick(); bus.errR = 1'b0; bus.doneR = 1'b0;
        check_eq("t2_fault_code", int'(bus.fault_code), 2);
        check_eq("t2_fault_en",   en_vec(), 0);
        check_eq("t2_fault_busy", int'(bus.busy), 0);
        check_eq("t2_fault_rd",   int'(bus.route_done), 0);
        repeat (3) tick();
        check_eq("t2_fault_hold", int'(bus.fault_code), 2);
        $display("route t2 complete");

        // STRAIGHT c3, never done: timeout after 20 WAIT cycles
        prog(3'd0, 4'b0011);
        prog(3'd1, 4'b1100);
        pulse_start();
        wait_en("t3_enS", 3'b001, 10);
        check_eq("t3_fault_cleared", int'(bus.fault_code), 0);
        check_eq("t3_countS",        int'(bus.count), 3);
        n = 0;
        while (bus.enS && n < 40) begin
            n++;
            tick();
        end
        check_eq("t3_wait_cycles", n, 20);
        check_eq("t3_fault_code",  int'(bus.fault_code), 1);
        check_eq("t3_fault_en",    en_vec(), 0);
        check_eq("t3_fault_busy",  int'(bus.busy), 0);
        bus.abort = 1'b1; tick(); bus.abort = 1'b0;
        check_eq("t3_abort_keeps_fault", int'(bus.fault_code), 1);
        $display("route t3 complete");

        // done arriving in the final watchdog cycle wins over timeout
        pulse_start();
        wait_en("t4_enS", 3'b001, 10);
        repeat (19) tick();
        check_eq("t4_still_wait", en_vec(), 3'b001);
        bus.doneS = 1'b1; tick(); bus.doneS = 1'b0;
        check_eq("t4_settle_busy", int'(bus.busy), 1);
        check_eq("t4_no_fault",    int'(bus.fault_code), 0);
        wait_done("t4_done", 20);
        $display("route t4 complete");

        // All eight entries LEFT c0: no wrap past the last entry
        for (int i = 0; i < 8; i++) prog(3'(i), 4'b0100);
        pulse_start();
        for (int s = 0; s < 8; s++) begin
            wait_en($sformatf("t5_enL_%0d", s), 3'b010, 20);
            check_eq($sformatf("t5_step_%0d", s), int'(bus.step_idx), s);
            bus.doneL = 1'b1; tick(); bus.doneL = 1'b0;
        end
        wait_done("t5_done", 20);
        check_eq("t5_last_step", int'(bus.step_idx), 7);
        repeat (5) tick();
        check_eq("t5_no_wrap",   int'(bus.step_idx), 7);
        check_eq("t5_done_hold", int'(bus.route_done), 1);
        check_eq("t5_done_en",   en_vec(), 0);
        $display("route t5 complete");

        // Abort beats start; writes during WAIT are dropped
        prog(3'd0, 4'b0001);
        prog(3'd1, 4'b1100);
        pulse_start();
        wait_en("t6_enS", 3'b001, 10);
        prog(3'd0, 4'b1010);
        bus.abort = 1'b1; bus.start = 1'b1; tick(); bus.abort = 1'b0; bus.start = 1'b0;
        check_eq("t6_abort_en",   en_vec(), 0);
        check_eq("t6_abort_busy", int'(bus.busy), 0);
        check_eq("t6_abort_step", int'(bus.step_idx), 0);
        check_eq("t6_abort_rd",   int'(bus.route_done), 0);
        pulse_start();
        wait_en("t6_readback_enS", 3'b001, 10);
        check_eq("t6_readback_count", int'(bus.count), 1);
        $display("route t6 complete");

        // Asynchronous reset in WAIT clears outputs before the next edge
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("t7_async_en",    en_vec(), 0);
        check_eq("t7_async_count", int'(bus.count), 0);
        check_eq("t7_async_busy",  int'(bus.busy), 0);
        check_eq("t7_async_step",  int'(bus.step_idx), 0);
        tick();
        rst_n = 1'b1;
        repeat (4) tick();
        check_eq("t7_idle_busy", int'(bus.busy), 0);
        check_eq("t7_idle_en",   en_vec(), 0);
        // table returned to STOP: a new start finishes without enabling anything
        pulse_start();
        wait_done("t7_stop_table_done", 10);
        check_eq("t7_stop_table_en", en_vec(), 0);
        $display("route t7 complete");

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end
endmodule

// File: doc/route_sequencer.md
ROUTE_SEQUENCER -- requirements
Module: route_sequencer

Interface
REQ-001 Parameter NSTEPS, default 8: number of route program entries; power of two, 2..16.
REQ-002 Parameter TIMEOUT, default 24'd10_000_000: max cycles a step may stay in WAIT before fault.
REQ-003 Parameter SETTLE, default 4: cycles all enables held low between steps.
REQ-004 clk  in  1  system clock; all state on rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 prog_we  in  1  write strobe for route table.
REQ-007 prog_addr  in  log2(NSTEPS)  table entry index.
REQ-008 prog_data  in  4  entry: [3:2] action (00 STRAIGHT, 01 LEFT, 10 RIGHT, 11 STOP), [1:0] intersection count.
REQ-009 start  in  1  level-sampled; begins route at entry 0.
REQ-010 abort  in  1  cancels active route.
REQ-011 doneS, doneL, doneR  in  1 each  completion flags from straight/left/right detectors.
REQ-012 errL, errR  in  1 each  error flags from left/right detectors.
REQ-013 enS, enL, enR  out  1 each  detector/maneuver enables; at most one high.
REQ-014 count  out  2  intersection count for active step.
REQ-015 step_idx  out  log2(NSTEPS)  index of current step.
REQ-016 busy  out  1  high in ISSUE, WAIT, SETTLE.
REQ-017 route_done  out  1  high in DONE.
REQ-018 fault_code  out  2  00 none, 01 timeout, 10 detector error; valid in FAULT.

Function
REQ-019 States SHALL be IDLE, ISSUE, WAIT, SETTLE, DONE, FAULT, registered, one state per cycle minimum.
REQ-020 Table write SHALL occur on clk edge when prog_we=1 and busy=0; writes while busy ignored.
REQ-021 IDLE/DONE/FAULT + start=1 -> ISSUE with step_idx=0, fault_code cleared, timeout counter cleared; start while busy ignored.
REQ-022 ISSUE: entry action STOP -> DONE; else latch count from entry, assert the matching enable next cycle, -> WAIT.
REQ-023 WAIT: enable and count held stable; timeout counter increments each cycle.
REQ-024 WAIT: done of active action only -> SETTLE; done from inactive detectors ignored.
REQ-025 WAIT: errL (LEFT step) or errR (RIGHT step) -> FAULT, fault_code=10; err of inactive detector ignored.
REQ-026 WAIT: counter reaching TIMEOUT-1 without done -> FAULT, fault_code=01; same-cycle done and timeout: done wins.
REQ-027 Same-cycle done and err of active detector: err wins (FAULT, 10).
REQ-028 SETTLE: all enables low for exactly SETTLE cycles; then step_idx==NSTEPS-1 -> DONE, else step_idx+1 and -> ISSUE.
REQ-029 step_idx SHALL NOT wrap; last entry completion ends route.
REQ-030 abort=1 in any state -> IDLE next cycle, enables low, step_idx=0, fault_code unchanged; abort beats start.
REQ-031 DONE and FAULT hold until start or abort; enables low in both.
REQ-032 Enables and count SHALL be registered outputs, glitch-free, one-hot-or-zero.

Reset
REQ-033 rst_n=0 SHALL immediately force IDLE, enS=enL=enR=0, count=0, step_idx=0, busy=0, route_done=0, fault_code=00, counters 0.
REQ-034 Route table contents SHALL reset to all STOP (4'b1100).
REQ-035 Reset deassertion mid-route SHALL resume in IDLE; no step restarted without start.

Verification
REQ-036 Table {LEFT c2, RIGHT c1, STOP}, start; pulse doneL then doneR after enables seen -> enL=1,count=2; SETTLE 4 low cycles; enR=1,count=1; route_done=1, step_idx=2.
REQ-037 Table {STRAIGHT c3}, start, never done, TIMEOUT=20 -> FAULT after 20 WAIT cycles, fault_code=01, enS=0.
REQ-038 RIGHT step, assert doneL and errL in WAIT -> ignored; then errR -> FAULT, fault_code=10.
REQ-039 All 8 entries LEFT c0, doneL each step -> 8 enL pulses, route_done after step_idx=7, no wrap.
REQ-040 Mid-WAIT abort with start=1 same cycle -> IDLE, enables 0; prog_we during WAIT leaves table unchanged (readback via next route).
REQ-041 Assert rst_n=0 asynchronously mid-WAIT -> outputs zero before next clk edge; after release stays IDLE.
